// File: rtl/mm_stream_sink_if.sv
// Signal bundle for mm_stream_sink: Avalon-ST sink handshake plus Avalon-MM read slave.
// The master modport is the environment side; the slave modport is the bridge side.
interface mm_stream_sink_if;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_ready;
  logic [1:0]  avs_s0_address;
  logic        avs_s0_read;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_readdatavalid;
  logic        avs_s0_waitrequest;

  modport master (
    output asi_in0_data, asi_in0_valid, avs_s0_address, avs_s0_read,
    input  asi_in0_ready, avs_s0_readdata, avs_s0_readdatavalid, avs_s0_waitrequest
  );

  modport slave (
    input  asi_in0_data, asi_in0_valid, avs_s0_address, avs_s0_read,
    output asi_in0_ready, avs_s0_readdata, avs_s0_readdatavalid, avs_s0_waitrequest
  );
endinterface

// File: rtl/mm_stream_sink.sv
// Avalon-ST sink feeding a word FIFO that an Avalon-MM master drains (addr 0) and polls (addr 1).
// Optional accepted-word counter at addr 2 when MM_STREAM_SINK_COUNT_EN is defined.
module mm_stream_sink #(
  parameter int DEPTH = 16
) (
  input  logic               csi_clk,
  input  logic               rsi_reset,
  mm_stream_sink_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          rdv_q, rdv_d;

  logic          empty_s, full_s, ready_s, wait_s, accept_s, push_s, pop_s;
  logic [31:0]   status_s, count_rd_s;

  assign empty_s  = (fill_q == {(AW+1){1'b0}});
  assign full_s   = (fill_q == FILL_FULL);
  assign ready_s  = !full_s && !rsi_reset;
  assign wait_s   = bus.avs_s0_read && (bus.avs_s0_address == 2'd0) && empty_s;
  assign accept_s = bus.avs_s0_read && !wait_s;
  assign push_s   = bus.asi_in0_valid && ready_s;
  // A data read is only accepted when non-empty, so pop never underflows.
  assign pop_s    = accept_s && (bus.avs_s0_address == 2'd0);
  assign status_s = {14'd0, full_s, empty_s, 16'(fill_q)};

  assign bus.asi_in0_ready        = ready_s;
  assign bus.avs_s0_waitrequest   = wait_s;
  assign bus.avs_s0_readdata      = readdata_q;
  assign bus.avs_s0_readdatavalid = rdv_q;

`ifdef MM_STREAM_SINK_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    if (push_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_rd_s = count_q;
`else
  assign count_rd_s = 32'h0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    readdata_d = readdata_q;
    rdv_d      = accept_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
    // STATUS reflects the fill before this edge's push/pop.
    if (accept_s) begin
      case (bus.avs_s0_address)
        2'd0:    readdata_d = mem_q[rd_ptr_q];
        2'd1:    readdata_d = status_s;
        2'd2:    readdata_d = count_rd_s;
        default: readdata_d = 32'h0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.asi_in0_data;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      fill_q     <= {(AW+1){1'b0}};
      readdata_q <= 32'h0;
      rdv_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
    end
  end
endmodule

// File: tb/tb_mm_stream_sink.sv
// Directed self-checking bench for mm_stream_sink (DEPTH=16); inputs change and outputs are sampled on negedges.
module tb_mm_stream_sink;
  logic csi_clk;
  logic rsi_reset;
  int   chk_cnt;
  int   pass_cnt;

  mm_stream_sink_if bus ();

  mm_stream_sink #(.DEPTH(16)) dut (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .bus       (bus.slave)
  );

  initial csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.asi_in0_valid = 1'b1;
      bus.asi_in0_data  = base + 32'(i);
      @(negedge csi_clk);
    end
    bus.asi_in0_valid = 1'b0;
  endtask

  // Issue one MM read; returns the data/valid seen one cycle after acceptance.
  task automatic mm_rd(input logic [1:0] a, output logic [31:0] d, output logic v);
    int waits;
    waits = 0;
    bus.avs_s0_read    = 1'b1;
    bus.avs_s0_address = a;
    #1;
    while (bus.avs_s0_waitrequest && waits < 64) begin
      @(negedge csi_clk);
      waits++;
      #1;
    end
    @(negedge csi_clk);
    bus.avs_s0_read = 1'b0;
    v = bus.avs_s0_readdatavalid;
    d = bus.avs_s0_readdata;
  endtask

  task automatic reset_dut();
    rsi_reset = 1'b1;
    @(negedge csi_clk);
    @(negedge csi_clk);
    rsi_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    rsi_reset = 1'b1;
    @(negedge csi_clk);
    @(negedge csi_clk);
    chk_cnt++; if (bus.asi_in0_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus.asi_in0_ready); else pass_cnt++;
    chk_cnt++; if (bus.avs_s0_readdatavalid !== 1'b0) $display("FAIL rst_rdv: got %b expected 0", bus.avs_s0_readdatavalid); else pass_cnt++;
    chk_cnt++; if (bus.avs_s0_readdata !== 32'h0) $display("FAIL rst_readdata: got %h expected 00000000", bus.avs_s0_readdata); else pass_cnt++;
    rsi_reset = 1'b0;
    #1;
    chk_cnt++; if (bus.asi_in0_ready !== 1'b1) $display("FAIL post_rst_ready: got %b expected 1", bus.asi_in0_ready); else pass_cnt++;
    bus.avs_s0_read = 1'b1;
    bus.avs_s0_address = 2'd0;
    #1;
    chk_cnt++; if (bus.avs_s0_waitrequest !== 1'b1) $display("FAIL empty_wait_addr0: got %b expected 1", bus.avs_s0_waitrequest); else pass_cnt++;
    bus.avs_s0_address = 2'd1;
    #1;
    chk_cnt++; if (bus.avs_s0_waitrequest !== 1'b0) $display("FAIL wait_addr1: got %b expected 0", bus.avs_s0_waitrequest); else pass_cnt++;
    bus.avs_s0_read = 1'b0;
    @(negedge csi_clk);
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h0001_0000) $display("FAIL rst_status: got v=%b %h expected v=1 00010000", v, d); else pass_cnt++;
    mm_rd(2'd3, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h0) $display("FAIL addr3: got v=%b %h expected v=1 00000000", v, d); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic v;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hA1; exp_w[1] = 32'hB2; exp_w[2] = 32'hC3;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      bus.asi_in0_valid = 1'b1;
      bus.asi_in0_data  = exp_w[i];
      @(negedge csi_clk);
    end
    bus.asi_in0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mm_rd(2'd0, d, v);
      chk_cnt++; if (v !== 1'b1 || d !== exp_w[i]) $display("FAIL basic_pop%0d: got v=%b %h expected v=1 %h", i, v, d, exp_w[i]); else pass_cnt++;
    end
    @(negedge csi_clk);
    chk_cnt++; if (bus.avs_s0_readdatavalid !== 1'b0 || bus.avs_s0_readdata !== 32'hC3) $display("FAIL rdv_pulse_hold: got v=%b %h expected v=0 000000c3", bus.avs_s0_readdatavalid, bus.avs_s0_readdata); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [31:0] d;
    logic v;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      bus.asi_in0_valid = 1'b1;
      bus.asi_in0_data  = 32'h100 + 32'(i);
      @(negedge csi_clk);
    end
    bus.asi_in0_data = 32'h110;
    #1;
    chk_cnt++; if (bus.asi_in0_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", bus.asi_in0_ready); else pass_cnt++;
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h0002_0010) $display("FAIL full_status: got v=%b %h expected v=1 00020010", v, d); else pass_cnt++;
    mm_rd(2'd0, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h100) $display("FAIL full_pop: got v=%b %h expected v=1 00000100", v, d); else pass_cnt++;
    chk_cnt++; if (bus.asi_in0_ready !== 1'b1) $display("FAIL ready_after_pop: got %b expected 1", bus.asi_in0_ready); else pass_cnt++;
    @(negedge csi_clk);
    bus.asi_in0_valid = 1'b0;
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h0002_0010) $display("FAIL refill_status: got v=%b %h expected v=1 00020010", v, d); else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      mm_rd(2'd0, d, v);
      chk_cnt++; if (v !== 1'b1 || d !== 32'h100 + 32'(i)) $display("FAIL full_order%0d: got v=%b %h expected v=1 %h", i, v, d, 32'h100 + 32'(i)); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    reset_dut();
    bus.avs_s0_read    = 1'b1;
    bus.avs_s0_address = 2'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cnt++; if (bus.avs_s0_waitrequest !== 1'b1) $display("FAIL stall_wait%0d: got %b expected 1", i, bus.avs_s0_waitrequest); else pass_cnt++;
      @(negedge csi_clk);
    end
    bus.asi_in0_valid = 1'b1;
    bus.asi_in0_data  = 32'h55;
    #1;
    chk_cnt++; if (bus.avs_s0_waitrequest !== 1'b1) $display("FAIL stall_push_cycle: got %b expected 1", bus.avs_s0_waitrequest); else pass_cnt++;
    @(negedge csi_clk);
    bus.asi_in0_valid = 1'b0;
    #1;
    chk_cnt++; if (bus.avs_s0_waitrequest !== 1'b0) $display("FAIL stall_release: got %b expected 0", bus.avs_s0_waitrequest); else pass_cnt++;
    @(negedge csi_clk);
    bus.avs_s0_read = 1'b0;
    chk_cnt++; if (bus.avs_s0_readdatavalid !== 1'b1 || bus.avs_s0_readdata !== 32'h55) $display("FAIL stall_data: got v=%b %h expected v=1 00000055", bus.avs_s0_readdatavalid, bus.avs_s0_readdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v;
    reset_dut();
    push_seq(32'h200, 4);
    for (int i = 0; i < 10; i++) begin
      bus.asi_in0_valid  = 1'b1;
      bus.asi_in0_data   = 32'h204 + 32'(i);
      bus.avs_s0_read    = 1'b1;
      bus.avs_s0_address = 2'd0;
      @(negedge csi_clk);
      chk_cnt++; if (bus.avs_s0_readdatavalid !== 1'b1 || bus.avs_s0_readdata !== 32'h200 + 32'(i)) $display("FAIL b2b_pop%0d: got v=%b %h expected v=1 %h", i, bus.avs_s0_readdatavalid, bus.avs_s0_readdata, 32'h200 + 32'(i)); else pass_cnt++;
    end
    bus.asi_in0_valid = 1'b0;
    bus.avs_s0_read   = 1'b0;
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h4) $display("FAIL b2b_status: got v=%b %h expected v=1 00000004", v, d); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      mm_rd(2'd0, d, v);
      chk_cnt++; if (v !== 1'b1 || d !== 32'h20A + 32'(i)) $display("FAIL b2b_tail%0d: got v=%b %h expected v=1 %h", i, v, d, 32'h20A + 32'(i)); else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic v;
    reset_dut();
    push_seq(32'h300, 6);
    bus.asi_in0_valid = 1'b1;
    bus.asi_in0_data  = 32'h306;
    mm_rd(2'd1, d, v);
    bus.asi_in0_valid = 1'b0;
    chk_cnt++; if (v !== 1'b1 || d !== 32'h6) $display("FAIL status_pre_push: got v=%b %h expected v=1 00000006", v, d); else pass_cnt++;
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h7) $display("FAIL status_fill7: got v=%b %h expected v=1 00000007", v, d); else pass_cnt++;
    bus.avs_s0_read    = 1'b1;
    bus.avs_s0_address = 2'd0;
    @(negedge csi_clk);
    bus.avs_s0_read = 1'b0;
    rsi_reset = 1'b1;
    #1;
    chk_cnt++; if (bus.asi_in0_ready !== 1'b0) $display("FAIL midrst_ready: got %b expected 0", bus.asi_in0_ready); else pass_cnt++;
    @(negedge csi_clk);
    chk_cnt++; if (bus.avs_s0_readdatavalid !== 1'b0 || bus.avs_s0_readdata !== 32'h0) $display("FAIL midrst_rdv: got v=%b %h expected v=0 00000000", bus.avs_s0_readdatavalid, bus.avs_s0_readdata); else pass_cnt++;
    rsi_reset = 1'b0;
    #1;
    chk_cnt++; if (bus.asi_in0_ready !== 1'b1) $display("FAIL midrst_ready_after: got %b expected 1", bus.asi_in0_ready); else pass_cnt++;
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'h0001_0000) $display("FAIL midrst_status: got v=%b %h expected v=1 00010000", v, d); else pass_cnt++;
    bus.avs_s0_read    = 1'b1;
    bus.avs_s0_address = 2'd0;
    #1;
    chk_cnt++; if (bus.avs_s0_waitrequest !== 1'b1) $display("FAIL midrst_wait: got %b expected 1", bus.avs_s0_waitrequest); else pass_cnt++;
    bus.avs_s0_read = 1'b0;
    @(negedge csi_clk);
  endtask

  task automatic test_count();
    logic [31:0] d;
    logic v;
    logic [31:0] exp_cnt;
`ifdef MM_STREAM_SINK_COUNT_EN
    exp_cnt = 32'd20;
`else
    exp_cnt = 32'd0;
`endif
    reset_dut();
    push_seq(32'h400, 10);
    for (int i = 0; i < 10; i++) begin
      mm_rd(2'd0, d, v);
    end
    chk_cnt++; if (v !== 1'b1 || d !== 32'h409) $display("FAIL count_drain: got v=%b %h expected v=1 00000409", v, d); else pass_cnt++;
    push_seq(32'h40A, 10);
    mm_rd(2'd2, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== exp_cnt) $display("FAIL count_read: got v=%b %h expected v=1 %h", v, d, exp_cnt); else pass_cnt++;
    mm_rd(2'd1, d, v);
    chk_cnt++; if (v !== 1'b1 || d !== 32'hA) $display("FAIL count_no_side_effect: got v=%b %h expected v=1 0000000a", v, d); else pass_cnt++;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    rsi_reset = 1'b1;
    bus.asi_in0_data   = 32'h0;
    bus.asi_in0_valid  = 1'b0;
    bus.avs_s0_address = 2'd0;
    bus.avs_s0_read    = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_count();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
